// File: rtl/dense_weight_sched.sv
// ---------------------------------------------------------------------------
// dense_weight_sched
// Sequencer and weight-BRAM arbiter for the dense forward layer.
// A start request launches one forward pass: fwd_run is raised and the BRAM
// read address walks 0..WORDS-1 in lock-step with the forward block's
// (row, chunk) counter, so read data lines up with its one-cycle-delayed
// index. The pass ends on fwd_valid, or is abandoned on stop. While idle,
// the single-port BRAM is lent to the weight-update requester for writes.
//
// Ports
//   clk, rst_n          : clock (rising edge), async active-low reset
//   start               : request a pass (sampled in IDLE only)
//   stop                : abort the pass (honoured in RUN only)
//   busy                : high in RUN and DONE (registered)
//   done                : one-cycle pulse after a completed pass (registered)
//   fwd_run             : run enable of the dense forward block (registered)
//   fwd_valid           : valid from the dense forward block
//   upd_req/addr/wdata  : weight-update write request, held until granted
//   upd_gnt             : write accepted this cycle (combinational)
//   mem_en/we/addr/wdata: BRAM port (combinational mux of read/write source)
// ---------------------------------------------------------------------------
module dense_weight_sched #(
    parameter int unsigned DENSE_DATA_N = 8,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned HID_DIM      = 24,
    parameter int unsigned CHAR_NUM     = 200,
    parameter int unsigned N_LEN        = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            stop,
    output logic                            busy,
    output logic                            done,
    output logic                            fwd_run,
    input  logic                            fwd_valid,
    input  logic                            upd_req,
    input  logic [ADDR_W-1:0]               upd_addr,
    input  logic [DENSE_DATA_N*N_LEN-1:0]   upd_wdata,
    output logic                            upd_gnt,
    output logic                            mem_en,
    output logic                            mem_we,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DENSE_DATA_N*N_LEN-1:0]   mem_wdata
);

    localparam int unsigned DATA_W = DENSE_DATA_N * N_LEN;
    // Number of BRAM words holding the whole weight matrix; ADDR_W must cover WORDS-1.
    localparam int unsigned WORDS  = (CHAR_NUM * HID_DIM) / DENSE_DATA_N;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_raddr;
    logic                r_busy;
    logic                r_done;
    logic                r_fwd_run;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_fwd_run_nxt;

    // State register plus the registered status outputs, which are
    // precomputed from the next state so they change glitch-free with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_fwd_run <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_fwd_run <= w_fwd_run_nxt;
        end
    end

    // Next-state logic; fwd_valid beats stop when both arrive together.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (fwd_valid) begin
                    w_state_nxt = S_DONE;
                end else if (stop) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered flags, and the BRAM port mux.
    always_comb begin
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_fwd_run_nxt = 1'b0;
        upd_gnt       = 1'b0;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;

        case (w_state_nxt)
            S_RUN: begin
                w_busy_nxt    = 1'b1;
                w_fwd_run_nxt = 1'b1;
            end
            S_DONE: begin
                w_busy_nxt    = 1'b1;
                w_done_nxt    = 1'b1;
            end
            default: begin
                w_busy_nxt    = 1'b0;
            end
        endcase

        case (r_state)
            S_IDLE: begin
                // A start in the same cycle takes the port; the requester keeps waiting.
                if (upd_req && !start) begin
                    upd_gnt   = 1'b1;
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = upd_addr;
                    mem_wdata = upd_wdata;
                end
            end
            S_RUN: begin
                mem_en   = 1'b1;
                mem_addr = r_raddr;
            end
            default: begin
                mem_en   = 1'b0;
            end
        endcase
    end

    // Read address: cleared on launch, then one word per RUN cycle,
    // parking on the last word until the forward block reports valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raddr <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_raddr <= '0;
            end
        end else if (r_state == S_RUN) begin
            if (r_raddr != LAST_ADDR) begin
                r_raddr <= r_raddr + ADDR_W'(1);
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign fwd_run = r_fwd_run;

    // DATA_W documents the BRAM word width used by the data ports.
    if (DATA_W == 0) begin : g_no_data
        initial $fatal(1, "DENSE_DATA_N*N_LEN must be non-zero");
    end

endmodule

// File: tb/tb_dense_weight_sched.sv
// Testbench for dense_weight_sched: behavioural BRAM, a behavioural dense
// forward block (counter + one-cycle delayed index + order-sensitive
// accumulator), table vectors for idle arbitration, random idle vectors and
// random writes, and hand-written sequences for stop, reset and collisions.
module tb_dense_weight_sched;

    localparam int unsigned HID_DIM  = 24;
    localparam int unsigned CHAR_NUM = 200;
    localparam int unsigned DN       = 8;
    localparam int unsigned N_LEN    = 8;
    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned DW       = DN * N_LEN;
    localparam int          NW       = int'((CHAR_NUM * HID_DIM) / DN);
    localparam int          CPR      = int'(HID_DIM / DN);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              stop;
    logic              busy;
    logic              done;
    logic              fwd_run;
    logic              fwd_valid = 1'b0;
    logic              upd_req;
    logic [ADDR_W-1:0] upd_addr;
    logic [DW-1:0]     upd_wdata;
    logic              upd_gnt;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DW-1:0]     mem_wdata;

    dense_weight_sched #(
        .DENSE_DATA_N (DN),
        .ADDR_W       (ADDR_W),
        .HID_DIM      (HID_DIM),
        .CHAR_NUM     (CHAR_NUM),
        .N_LEN        (N_LEN)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .busy      (busy),
        .done      (done),
        .fwd_run   (fwd_run),
        .fwd_valid (fwd_valid),
        .upd_req   (upd_req),
        .upd_addr  (upd_addr),
        .upd_wdata (upd_wdata),
        .upd_gnt   (upd_gnt),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural single-port BRAM, one-cycle read latency
    logic [DW-1:0] bram [NW];
    logic [DW-1:0] rdata = '0;
    always @(posedge clk) begin
        if (mem_en && (int'(mem_addr) < NW)) begin
            if (mem_we) bram[mem_addr] <= mem_wdata;
            else        rdata          <= bram[mem_addr];
        end
    end

    // Behavioural dense forward block: index counter runs while run is high,
    // data is consumed with a one-cycle delayed index, valid after last word.
    int            fcnt  = 0;
    int            d_idx = 0;
    bit            d_v   = 1'b0;
    logic [63:0]   q     = '0;
    logic [DW-1:0] cap_word = '0;
    always @(posedge clk) begin
        if (fwd_run) begin
            if (fcnt < NW) fcnt <= fcnt + 1;
            d_v   <= (fcnt < NW);
            d_idx <= fcnt;
            if (fcnt == 0) q <= '0;
        end else begin
            fcnt <= 0;
            d_v  <= 1'b0;
        end
        fwd_valid <= d_v && (d_idx == NW - 1);
        if (d_v) begin
            q <= q * 64'd3 + 64'(rdata);
            if (d_idx == 12 * CPR + 1) cap_word <= rdata;
        end
    end

    // Monitors
    int cyc = 0, valid_cyc = -1, done_cyc = -2, done_cnt = 0;
    int run_cyc = 0, addr_err = 0, gnt_busy = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fwd_valid) valid_cyc <= cyc + 1;
    end
    always @(negedge clk) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (busy && upd_gnt) gnt_busy <= gnt_busy + 1;
        if (fwd_run) begin
            if (int'(mem_addr) != ((run_cyc < NW - 1) ? run_cyc : NW - 1) || !mem_en || mem_we)
                addr_err <= addr_err + 1;
            run_cyc <= run_cyc + 1;
        end else begin
            run_cyc <= 0;
        end
    end

    logic [DW-1:0] ref_mem [NW];

    function automatic logic [63:0] golden();
        logic [63:0] a = '0;
        for (int k = 0; k < NW; k++) a = a * 64'd3 + 64'(ref_mem[k]);
        return a;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_addr(input int a, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (fwd_run && int'(mem_addr) == a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_pass(input string tag, input bit stray);
        int d0, e0, g0;
        bit ok;
        d0 = done_cnt; e0 = addr_err; g0 = gnt_busy;
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_run"}, 64'(fwd_run), 64'd1);
        chk({tag, "_addr0"}, 64'(mem_addr), 64'd0);
        if (stray) begin
            repeat (50) tick();
            start = 1'b1;
            tick(); start = 1'b0;
        end
        wait_done(NW + 50, ok);
        chk({tag, "_done_seen"}, 64'(ok), 64'd1);
        if (ok) begin
            chk({tag, "_run_in_done"}, 64'(fwd_run), 64'd0);
            chk({tag, "_done_after_valid"}, 64'(done_cyc), 64'(valid_cyc));
            chk({tag, "_q"}, q, golden());
            tick();
            chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
            chk({tag, "_idle_done"}, 64'(done), 64'd0);
            chk({tag, "_idle_run"}, 64'(fwd_run), 64'd0);
        end
        repeat (3) tick();
        chk({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, "_addr_seq_err"}, 64'(addr_err - e0), 64'd0);
        chk({tag, "_gnt_in_busy"}, 64'(gnt_busy - g0), 64'd0);
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d);
        tick();
        upd_req = 1'b1; upd_addr = ADDR_W'(a); upd_wdata = d;
        #1;
        chk("wr_gnt", 64'(upd_gnt), 64'd1);
        chk("wr_we", 64'(mem_we), 64'd1);
        chk("wr_addr", 64'(mem_addr), 64'(a));
        chk("wr_data", 64'(mem_wdata), 64'(d));
        ref_mem[a] = d;
        tick();
        upd_req = 1'b0;
    endtask

    typedef struct {
        bit                st;
        bit                req;
        logic [ADDR_W-1:0] addr;
        logic [DW-1:0]     wd;
        bit                e_gnt;
        bit                e_en;
        bit                e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [DW-1:0]     e_wd;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int d0, g0, errs;
        bit ok;
        logic [DW-1:0] pat;

        tbl[0] = '{1'b0, 1'b0, 10'd5,   64'hAAAA_5555_0000_1111, 1'b0, 1'b0, 1'b0, 10'd0,   64'h0};
        tbl[1] = '{1'b0, 1'b1, 10'd37,  64'hDEAD_BEEF_0123_4567, 1'b1, 1'b1, 1'b1, 10'd37,  64'hDEAD_BEEF_0123_4567};
        tbl[2] = '{1'b1, 1'b1, 10'd37,  64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0, 1'b0, 10'd0,   64'h0};
        tbl[3] = '{1'b1, 1'b0, 10'd12,  64'h1111_2222_3333_4444, 1'b0, 1'b0, 1'b0, 10'd0,   64'h0};
        tbl[4] = '{1'b0, 1'b1, 10'd0,   64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1, 10'd0,   64'hFFFF_FFFF_FFFF_FFFF};
        tbl[5] = '{1'b0, 1'b1, 10'd599, 64'h0F0F_F0F0_0F0F_F0F0, 1'b1, 1'b1, 1'b1, 10'd599, 64'h0F0F_F0F0_0F0F_F0F0};

        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        upd_req = 1'b0; upd_addr = '0; upd_wdata = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_run", 64'(fwd_run), 64'd0);
        chk("rst_gnt", 64'(upd_gnt), 64'd0);
        chk("rst_en", 64'(mem_en), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);

        // Idle arbitration vectors; inputs drop before the next edge
        for (int i = 0; i < 6; i++) begin
            tick();
            start = tbl[i].st; upd_req = tbl[i].req;
            upd_addr = tbl[i].addr; upd_wdata = tbl[i].wd;
            #1;
            chk($sformatf("vec%0d_gnt", i), 64'(upd_gnt), 64'(tbl[i].e_gnt));
            chk($sformatf("vec%0d_en", i), 64'(mem_en), 64'(tbl[i].e_en));
            chk($sformatf("vec%0d_we", i), 64'(mem_we), 64'(tbl[i].e_we));
            chk($sformatf("vec%0d_addr", i), 64'(mem_addr), 64'(tbl[i].e_addr));
            chk($sformatf("vec%0d_wd", i), 64'(mem_wdata), 64'(tbl[i].e_wd));
            start = 1'b0; upd_req = 1'b0;
        end

        // Random idle arbitration against the grant rule
        for (int i = 0; i < 40; i++) begin
            bit s, r, eg;
            int a;
            logic [DW-1:0] d;
            s = 1'($urandom % 2); r = 1'($urandom % 2);
            a = int'($urandom % NW); d = {$urandom, $urandom};
            eg = r && !s;
            tick();
            start = s; upd_req = r; upd_addr = ADDR_W'(a); upd_wdata = d;
            #1;
            chk("rnd_gnt", 64'(upd_gnt), 64'(eg));
            chk("rnd_we", 64'(mem_we), 64'(eg));
            chk("rnd_addr", 64'(mem_addr), eg ? 64'(a) : 64'd0);
            chk("rnd_wd", 64'(mem_wdata), eg ? 64'(d) : 64'd0);
            start = 1'b0; upd_req = 1'b0;
        end

        // Fill weight memory through the write port
        errs = 0;
        for (int k = 0; k < NW; k++) begin
            tick();
            upd_req = 1'b1; upd_addr = ADDR_W'(k); upd_wdata = {$urandom, $urandom};
            ref_mem[k] = upd_wdata;
            #1;
            if (!upd_gnt || !mem_we || int'(mem_addr) != k) errs++;
        end
        tick(); upd_req = 1'b0;
        chk("bulk_load_gnt", 64'(errs), 64'd0);

        run_pass("pass1", 1'b0);

        // Single write, then read-back through a pass at row 12, chunk 1
        pat = 64'hC0FF_EE00_1234_ABCD;
        do_write(37, pat);
        run_pass("pass2", 1'b0);
        chk("readback_r12c1", 64'(cap_word), 64'(pat));

        for (int i = 0; i < 8; i++) do_write(int'($urandom % NW), {$urandom, $urandom});
        run_pass("pass3", 1'b0);

        // start and upd_req together: start wins, write waits for IDLE
        d0 = done_cnt; g0 = gnt_busy;
        pat = 64'h5A5A_0000_FFFF_A5A5;
        tick();
        start = 1'b1; upd_req = 1'b1; upd_addr = 10'd5; upd_wdata = pat;
        #1;
        chk("coll_gnt0", 64'(upd_gnt), 64'd0);
        tick(); start = 1'b0;
        chk("coll_busy", 64'(busy), 64'd1);
        wait_done(NW + 50, ok);
        chk("coll_done_seen", 64'(ok), 64'd1);
        chk("coll_gnt_done", 64'(upd_gnt), 64'd0);
        chk("coll_q", q, golden());
        tick();
        chk("coll_gnt_idle", 64'(upd_gnt), 64'd1);
        chk("coll_addr_idle", 64'(mem_addr), 64'd5);
        chk("coll_we_idle", 64'(mem_we), 64'd1);
        ref_mem[5] = pat;
        tick(); upd_req = 1'b0;
        chk("coll_gnt_in_busy", 64'(gnt_busy - g0), 64'd0);
        chk("coll_done_count", 64'(done_cnt - d0), 64'd1);

        // Abort at address 100
        d0 = done_cnt;
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        wait_addr(100, 300, ok);
        chk("stop_reach100", 64'(ok), 64'd1);
        stop = 1'b1;
        tick(); stop = 1'b0;
        chk("stop_run", 64'(fwd_run), 64'd0);
        chk("stop_busy", 64'(busy), 64'd0);
        chk("stop_en", 64'(mem_en), 64'd0);
        repeat (5) tick();
        chk("stop_no_done", 64'(done_cnt - d0), 64'd0);
        run_pass("after_stop", 1'b0);

        // Asynchronous reset mid-pass at address 300
        d0 = done_cnt;
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        wait_addr(300, 500, ok);
        chk("rst_reach300", 64'(ok), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_run", 64'(fwd_run), 64'd0);
        chk("arst_en", 64'(mem_en), 64'd0);
        chk("arst_addr", 64'(mem_addr), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_gnt", 64'(upd_gnt), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("arst_no_done", 64'(done_cnt - d0), 64'd0);
        run_pass("after_reset", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
